// File: rtl/arcade_video_gen.sv
// Core-side video timing source: pixel-clock enable, raster counters, blank/sync
// generation and a 1-clock-latency framebuffer fetch feeding a 1-pixel-late output stage.
module arcade_video_gen #(
    parameter int DW       = 8,
    parameter int CE_DIV   = 4,
    parameter int H_ACTIVE = 288,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 56,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 16,
    parameter int V_SYNC   = 8,
    parameter int V_BP     = 16
) (
    input  logic                                  clk_video,
    input  logic                                  reset_n,
    output logic                                  ce_pix,
    output logic [8:0]                            hcount,
    output logic [8:0]                            vcount,
    output logic [$clog2(H_ACTIVE*V_ACTIVE)-1:0]  fb_addr,
    input  logic [DW-1:0]                         fb_data,
    output logic [DW-1:0]                         RGB_out,
    output logic                                  HBlank,
    output logic                                  VBlank,
    output logic                                  HSync,
    output logic                                  VSync,
    output logic                                  frame_start
);

    localparam int AW      = $clog2(H_ACTIVE*V_ACTIVE);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIVW    = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CE_DIV - 1);
    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT    = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
    localparam logic [8:0] HS_START = 9'(H_ACTIVE + H_FP);
    localparam logic [8:0] HS_END   = 9'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0] VS_START = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0] VS_END   = 9'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIVW-1:0] div;
    logic            tick;
    logic [8:0]      h_next;
    logic [8:0]      v_next;
    logic [8:0]      line_next;
    logic            prev_active;
    logic            new_active;

    assign tick = (div == DIV_LAST);

    always_comb begin
        line_next = (vcount == V_LAST) ? '0 : vcount + 9'd1;
        h_next    = hcount + 9'd1;
        v_next    = vcount;
        if (hcount == H_LAST) begin
            h_next = '0;
            v_next = line_next;
        end
        prev_active = (hcount < H_ACT) && (vcount < V_ACT);
        new_active  = (h_next < H_ACT) && (v_next < V_ACT);
    end

    always_ff @(posedge clk_video) begin
        if (!reset_n) begin
            div         <= '0;
            ce_pix      <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            fb_addr     <= '0;
            RGB_out     <= '0;
            HBlank      <= 1'b0;
            VBlank      <= 1'b0;
            HSync       <= 1'b0;
            VSync       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            ce_pix <= tick;
            div    <= tick ? '0 : div + DIVW'(1);
            if (tick) begin
                hcount <= h_next;
                vcount <= v_next;
                // Active pixels are fetched in raster order, so the next address is just +1.
                if ((h_next == '0) && (v_next == '0))
                    fb_addr <= '0;
                else if (new_active)
                    fb_addr <= fb_addr + AW'(1);

                RGB_out     <= prev_active ? fb_data : '0;
                HBlank      <= (hcount >= H_ACT);
                HSync       <= (hcount >= HS_START) && (hcount < HS_END);
                frame_start <= (hcount == '0) && (vcount == '0);
                // Vertical flags only move inside horizontal blank so downstream latching is clean.
                if (hcount == H_ACT)
                    VBlank <= (line_next >= V_ACT);
                if (hcount == HS_START)
                    VSync <= (vcount >= VS_START) && (vcount < VS_END);
            end
        end
    end

endmodule
